// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the multi-master byte memory: FSM states,
// channel index type and the reset-vector overlay contents.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2
   } state_t;

   typedef logic [1:0] ch_idx_t;

   localparam logic [7:0] OVL_OPCODE = 8'hEA;
   localparam int         OVL_LEN    = 5;

   // Far jump: opcode, IP low, IP high, CS low, CS high.
   function automatic logic [7:0] ovl_byte(input logic [2:0]  off,
                                           input logic [15:0] ip,
                                           input logic [15:0] cs);
      logic [7:0] b;
      case (off)
         3'd0:    b = OVL_OPCODE;
         3'd1:    b = ip[7:0];
         3'd2:    b = ip[15:8];
         3'd3:    b = cs[7:0];
         default: b = cs[15:8];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/mem_bus_rr_arbiter.sv
// Combinational round-robin scan: picks the first eligible channel at or
// after pointer rr, wrapping modulo CH.
module rr_arbiter
   import mem_bus_pkg::*;
#(
   parameter int CH = 2
) (
   input  logic [CH-1:0] elig,
   input  ch_idx_t       rr,
   output ch_idx_t       grant,
   output logic          valid
);

   logic [2*CH-1:0] dbl;
   logic [CH-1:0]   rot;
   logic [2:0]      sum;

   always_comb begin
      dbl   = {elig, elig} >> rr;
      rot   = dbl[CH-1:0];
      valid = 1'b0;
      sum   = '0;
      // Descending scan so the lowest rotated position wins.
      for (int j = CH - 1; j >= 0; j--) begin
         if (rot[j]) begin
            sum   = 3'(rr) + 3'(j);
            valid = 1'b1;
         end
      end
      if (sum >= 3'(CH)) begin
         sum = sum - 3'(CH);
      end
      grant = sum[1:0];
   end

endmodule

// File: rtl/mem_bus.sv
// mem_bus: CH masters share one byte RAM through round-robin arbitration,
// WS wait states and a read-only reset-vector overlay at OVL_BASE.
module mem_bus
   import mem_bus_pkg::*;
#(
   parameter int            AW        = 20,
   parameter int            DW        = 8,
   parameter int            CH        = 2,
   parameter int            WS        = 0,
   parameter string         INIT_FILE = "",
   parameter bit            OVL_EN    = 1'b1,
   parameter logic [AW-1:0] OVL_BASE  = 20'hFFFF0,
   parameter logic [15:0]   BOOT_IP   = 16'h0000,
   parameter logic [15:0]   BOOT_CS   = 16'h0000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [CH-1:0]    req,
   input  logic [CH-1:0]    we,
   input  logic [CH*AW-1:0] address,
   input  logic [CH*DW-1:0] out,
   output logic [DW-1:0]    in,
   output logic [CH-1:0]    ready,
   output logic             busy
);

   logic [DW-1:0] mem [2**AW];

   state_t        state_q, state_d;
   ch_idx_t       rr_q, rr_d;
   ch_idx_t       gnt_q, gnt_d;
   logic [3:0]    wcnt_q, wcnt_d;
   logic          ph_q, ph_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          we_q, we_d;
   logic [DW-1:0] wdat_q, wdat_d;
   logic [CH-1:0] ready_q, ready_d;
   logic [DW-1:0] in_q, in_d;

   logic [CH-1:0] elig;
   ch_idx_t       arb_grant;
   logic          arb_valid;
   logic [AW-1:0] ovl_off;
   logic          ovl_hit;
   logic [DW-1:0] mem_rd;
   logic          mem_we;

   rr_arbiter #(.CH(CH)) u_arb (
      .elig  (elig),
      .rr    (rr_q),
      .grant (arb_grant),
      .valid (arb_valid)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         rr_q    <= '0;
         gnt_q   <= '0;
         wcnt_q  <= '0;
         ph_q    <= 1'b0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdat_q  <= '0;
         ready_q <= '0;
         in_q    <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         gnt_q   <= gnt_d;
         wcnt_q  <= wcnt_d;
         ph_q    <= ph_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdat_q  <= wdat_d;
         ready_q <= ready_d;
         in_q    <= in_d;
      end
   end

   // RAM has no reset; an aborted access never reaches ACCESS so never writes.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[addr_q] <= wdat_q;
      end
   end

   assign mem_rd  = mem[addr_q];
   assign ovl_off = addr_q - OVL_BASE;
   assign ovl_hit = OVL_EN && (ovl_off < AW'(OVL_LEN));

   // ACCESS spans two cycles: phase 0 touches the RAM, phase 1 issues ready.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      gnt_d   = gnt_q;
      wcnt_d  = wcnt_q;
      ph_d    = ph_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdat_d  = wdat_q;
      ready_d = '0;
      in_d    = in_q;
      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               gnt_d = arb_grant;
               for (int i = 0; i < CH; i++) begin
                  if (arb_grant == ch_idx_t'(i)) begin
                     addr_d = address[i*AW +: AW];
                     we_d   = we[i];
                     wdat_d = out[i*DW +: DW];
                  end
               end
               wcnt_d  = 4'(WS);
               ph_d    = 1'b0;
               state_d = (WS > 0) ? WAIT : ACCESS;
            end
         end
         WAIT: begin
            wcnt_d = wcnt_q - 4'd1;
            if (wcnt_q == 4'd1) begin
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (!ph_q) begin
               ph_d = 1'b1;
               if (!we_q) begin
                  in_d = ovl_hit ? ovl_byte(ovl_off[2:0], BOOT_IP, BOOT_CS) : mem_rd;
               end
            end else begin
               ph_d = 1'b0;
               for (int i = 0; i < CH; i++) begin
                  ready_d[i] = (gnt_q == ch_idx_t'(i));
               end
               rr_d    = (gnt_q == ch_idx_t'(CH - 1)) ? '0 : gnt_q + 2'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_we = (state_q == ACCESS) && !ph_q && we_q;
      elig   = req & ~ready_q;
      busy   = (state_q != IDLE) || (|ready_q);
      ready  = ready_q;
      in     = in_q;
   end

endmodule

// File: tb/tb_mem_bus.sv
// Directed bench for mem_bus: three instances (WS=0 with overlay, WS=3
// without overlay, WS=4 with overlay) driven through one linear sequence.
module tb_mem_bus;

   logic        clock;
   logic        reset;
   logic [1:0]  req     [3];
   logic [1:0]  we      [3];
   logic [39:0] address [3];
   logic [15:0] wdata   [3];
   logic [7:0]  rdata   [3];
   logic [1:0]  ready   [3];
   logic        busy    [3];

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [1:0] exp_ch_q[$];

   mem_bus #(.WS(0), .OVL_EN(1'b1), .BOOT_IP(16'h0100), .BOOT_CS(16'hF000)) dut_a (
      .clock(clock), .reset(reset), .req(req[0]), .we(we[0]), .address(address[0]),
      .out(wdata[0]), .in(rdata[0]), .ready(ready[0]), .busy(busy[0]));

   mem_bus #(.WS(3), .OVL_EN(1'b0)) dut_b (
      .clock(clock), .reset(reset), .req(req[1]), .we(we[1]), .address(address[1]),
      .out(wdata[1]), .in(rdata[1]), .ready(ready[1]), .busy(busy[1]));

   mem_bus #(.WS(4), .OVL_EN(1'b1)) dut_c (
      .clock(clock), .reset(reset), .req(req[2]), .we(we[2]), .address(address[2]),
      .out(wdata[2]), .in(rdata[2]), .ready(ready[2]), .busy(busy[2]));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One access on one channel; latency counts posedges after the sampling edge.
   task automatic access(input int inst, input int ch, input logic wr,
                         input logic [19:0] addr, input logic [19:0] alt,
                         input logic [7:0] data, input int exp_lat, input string tag);
      int         lat;
      logic [7:0] exp_b;
      repeat (2) @(negedge clock);
      address[inst][ch*20 +: 20] = addr;
      wdata[inst][ch*8 +: 8]     = data;
      we[inst][ch]               = wr;
      req[inst][ch]              = 1'b1;
      if (!wr) exp_q.push_back(data);
      lat = -1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clock);
         #1;
         if (k == 0) address[inst][ch*20 +: 20] = alt;
         if (ready[inst][ch]) begin
            lat = k;
            break;
         end
      end
      req[inst][ch] = 1'b0;
      we[inst][ch]  = 1'b0;
      check({tag, " latency"}, lat, exp_lat);
      if (!wr) begin
         exp_b = exp_q.pop_front();
         if (lat >= 0) check({tag, " data"}, 32'(rdata[inst]), 32'(exp_b));
      end
   endtask

   // Both channels read continuously; caller queues expected channel/byte order.
   task automatic dual_run(input int inst, input logic [19:0] a0, input logic [19:0] a1,
                           input int n, input string tag);
      int         got;
      logic [1:0] exp_c;
      logic [7:0] exp_b;
      repeat (2) @(negedge clock);
      address[inst] = {a1, a0};
      we[inst]      = 2'b00;
      req[inst]     = 2'b11;
      got = 0;
      for (int k = 0; k < 60 && got < n; k++) begin
         @(posedge clock);
         #1;
         check({tag, " busy"}, 32'(busy[inst]), 32'd1);
         if (ready[inst] != 2'b00) begin
            exp_c = exp_ch_q.pop_front();
            exp_b = exp_q.pop_front();
            got++;
            check({tag, " ready onehot"}, 32'(ready[inst]), 32'(2'b01 << exp_c));
            check({tag, " data"}, 32'(rdata[inst]), 32'(exp_b));
         end
      end
      req[inst] = 2'b00;
      check({tag, " count"}, got, n);
      exp_q.delete();
      exp_ch_q.delete();
   endtask

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req[i]     = '0;
         we[i]      = '0;
         address[i] = '0;
         wdata[i]   = '0;
      end
      repeat (3) @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) begin
         check("reset ready", 32'(ready[i]), 32'd0);
         check("reset busy", 32'(busy[i]), 32'd0);
         check("reset in", 32'(rdata[i]), 32'd0);
      end
      @(negedge clock);
      reset = 1'b0;

      // Boot vector overlay, WS=0
      access(0, 0, 1'b0, 20'hFFFF0, 20'hFFFF0, 8'hEA, 2, "boot0");
      access(0, 0, 1'b0, 20'hFFFF1, 20'hFFFF1, 8'h00, 2, "boot1");
      access(0, 0, 1'b0, 20'hFFFF2, 20'hFFFF2, 8'h01, 2, "boot2");
      access(0, 0, 1'b0, 20'hFFFF3, 20'hFFFF3, 8'h00, 2, "boot3");
      access(0, 0, 1'b0, 20'hFFFF4, 20'hFFFF4, 8'hF0, 2, "boot4");

      // Wait states, WS=3
      access(1, 0, 1'b1, 20'h00010, 20'h00010, 8'h5A, 5, "ws3 wr");
      access(1, 0, 1'b0, 20'h00010, 20'h00010, 8'h5A, 5, "ws3 rd");

      // Address change after grant must not affect the access
      access(0, 0, 1'b1, 20'h00020, 20'h00020, 8'h2C, 2, "pre20");
      access(0, 0, 1'b1, 20'h00030, 20'h00030, 8'h3D, 2, "pre30");
      access(0, 1, 1'b0, 20'h00020, 20'h00030, 8'h2C, 2, "addr chg");

      // Overlay wins on read; without overlay the written byte returns
      access(0, 0, 1'b1, 20'hFFFF0, 20'hFFFF0, 8'h11, 2, "ovl wr");
      access(0, 0, 1'b0, 20'hFFFF0, 20'hFFFF0, 8'hEA, 2, "ovl rd");
      access(1, 0, 1'b1, 20'hFFFF0, 20'hFFFF0, 8'h11, 5, "noovl wr");
      access(1, 0, 1'b0, 20'hFFFF0, 20'hFFFF0, 8'h11, 5, "noovl rd");

      // Round-robin alternation from a fresh pointer
      access(0, 0, 1'b1, 20'h00100, 20'h00100, 8'hA1, 2, "pre100");
      access(0, 0, 1'b1, 20'h00200, 20'h00200, 8'hB2, 2, "pre200");
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      for (int r = 0; r < 2; r++) begin
         exp_ch_q.push_back(2'd0);
         exp_q.push_back(8'hA1);
         exp_ch_q.push_back(2'd1);
         exp_q.push_back(8'hB2);
      end
      dual_run(0, 20'h00100, 20'h00200, 4, "alt");

      // Reset during WAIT of a write, WS=4; rr left at 1 beforehand
      access(2, 1, 1'b1, 20'h00041, 20'h00041, 8'h66, 6, "pre41");
      access(2, 0, 1'b1, 20'h00040, 20'h00040, 8'h77, 6, "pre40");
      repeat (2) @(negedge clock);
      address[2][19:0] = 20'h00040;
      wdata[2][7:0]    = 8'h99;
      we[2][0]         = 1'b1;
      req[2][0]        = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("abort busy before", 32'(busy[2]), 32'd1);
      reset = 1'b1;
      #1;
      check("abort ready", 32'(ready[2]), 32'd0);
      check("abort busy", 32'(busy[2]), 32'd0);
      req[2][0] = 1'b0;
      we[2][0]  = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      exp_ch_q.push_back(2'd0);
      exp_q.push_back(8'h77);
      exp_ch_q.push_back(2'd1);
      exp_q.push_back(8'h66);
      dual_run(2, 20'h00040, 20'h00041, 2, "post rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
